// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//
// Eight-phase instruction sequencer for the 8-bit accumulator CPU. A
// free-running phase counter steps through fetch and execute phases. The
// memory strobes and the PC/IR/accumulator controls are decoded
// combinationally from the current phase, the opcode (IR[7:5]) and the ALU
// zero flag. A HLT instruction sets a sticky halt flag at the end of P4. The
// sequencer then stays frozen in P5 until reset.
//
// Build option:
//   SEQ_SINGLE_STEP_EN - when defined, adds a 'step' input. The phase
//                        advances only on edges where step=1.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous, active-high reset
//   step    in   single-step enable (only with SEQ_SINGLE_STEP_EN)
//   opcode  in   IR[7:5] of the current instruction
//   zero    in   accumulator==0 flag from the ALU
//   sel     out  memory select (instruction-address phases)
//   rd      out  memory read
//   wr      out  memory write
//   ld_ir   out  load instruction register
//   data_e  out  accumulator drives the bidirectional data bus
//   inc_pc  out  increment program counter
//   ld_pc   out  load PC from the IR address field
//   ld_ac   out  load accumulator from the ALU
//   halt    out  CPU halted (sticky until reset)
//   phase   out  current phase, for debug
module cpu_sequencer #(
    parameter int OPC_WIDTH   = 3,
    parameter int PHASE_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                   step,
`endif
    input  logic [OPC_WIDTH-1:0]   opcode,
    input  logic                   zero,
    output logic                   sel,
    output logic                   rd,
    output logic                   wr,
    output logic                   ld_ir,
    output logic                   data_e,
    output logic                   inc_pc,
    output logic                   ld_pc,
    output logic                   ld_ac,
    output logic                   halt,
    output logic [PHASE_WIDTH-1:0] phase
);

    localparam logic [OPC_WIDTH-1:0] OPC_HLT = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] OPC_SKZ = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OPC_ADD = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] OPC_AND = OPC_WIDTH'(3);
    localparam logic [OPC_WIDTH-1:0] OPC_XOR = OPC_WIDTH'(4);
    localparam logic [OPC_WIDTH-1:0] OPC_LDA = OPC_WIDTH'(5);
    localparam logic [OPC_WIDTH-1:0] OPC_STO = OPC_WIDTH'(6);
    localparam logic [OPC_WIDTH-1:0] OPC_JMP = OPC_WIDTH'(7);

    typedef enum logic [PHASE_WIDTH-1:0] {
        P_INST_ADDR  = PHASE_WIDTH'(0),
        P_INST_FETCH = PHASE_WIDTH'(1),
        P_INST_LOAD  = PHASE_WIDTH'(2),
        P_IDLE       = PHASE_WIDTH'(3),
        P_OP_ADDR    = PHASE_WIDTH'(4),
        P_OP_FETCH   = PHASE_WIDTH'(5),
        P_ALU_OP     = PHASE_WIDTH'(6),
        P_STORE      = PHASE_WIDTH'(7)
    } phase_t;

    phase_t phase_q, phase_d;
    logic   halt_q, halt_d;
    logic   advance;
    logic   aluOp;
    logic   isSto;
    logic   isJmp;
    logic   isSkz;
    logic [PHASE_WIDTH-1:0] phaseInc;

    // Phase counter and sticky halt flag. Reset is synchronous and aborts
    // any instruction in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= P_INST_ADDR;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic. Once halted, the counter stops. Because halt is
    // set on the edge leaving P4, it stays frozen in P5.
    always_comb begin
`ifdef SEQ_SINGLE_STEP_EN
        advance = !halt_q && step;
`else
        advance = !halt_q;
`endif
        phaseInc = phase_q + PHASE_WIDTH'(1);
        phase_d  = advance ? phase_t'(phaseInc) : phase_q;
        halt_d   = halt_q || (advance && (phase_q == P_OP_ADDR) && (opcode == OPC_HLT));
    end

    // Output decode from phase and opcode. The opcode only matters from P4
    // onward, because the IR is loaded at the end of P2. The zero flag is
    // used only for SKZ in P6.
    always_comb begin
        aluOp  = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                 (opcode == OPC_XOR) || (opcode == OPC_LDA);
        isSto  = (opcode == OPC_STO);
        isJmp  = (opcode == OPC_JMP);
        isSkz  = (opcode == OPC_SKZ);
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        data_e = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        case (phase_q)
            P_INST_ADDR: begin
                sel = 1'b1;
            end
            P_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            P_INST_LOAD, P_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            P_OP_ADDR: begin
                inc_pc = 1'b1;
            end
            // Non-ALU ops leave every strobe low here so that memory latches
            // the operand address.
            P_OP_FETCH: begin
                rd = aluOp;
            end
            // STO drives the accumulator onto the bus one phase before the
            // write strobe, so the data is stable when wr rises.
            P_ALU_OP: begin
                rd     = aluOp;
                ld_ac  = aluOp;
                inc_pc = isSkz && zero;
                ld_pc  = isJmp;
                data_e = isSto;
            end
            P_STORE: begin
                rd     = aluOp;
                ld_ac  = aluOp;
                ld_pc  = isJmp;
                inc_pc = isJmp;
                wr     = isSto;
                data_e = isSto;
            end
            default: ;
        endcase
    end

    assign halt  = halt_q;
    assign phase = phase_q;

endmodule
